// File: rtl/debounce_pkg.sv
// Purpose : shared types and default parameters for the debounce_strobe block.
// Latency : n/a (package only).
// Backpressure: n/a; no flow control in this block.
package debounce_pkg;

  // Qualify FSM encoding; value 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 3;

endpackage

// File: rtl/sync_chain.sv
// Purpose : multi-flop synchronizer for one asynchronous bit.
// Latency : STAGES clocks from d to q.
// Backpressure: none; samples every clock.
// Ports   : clock, reset (async active-low), d (async in), q (synchronized out).
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_strobe.sv
// Purpose : debounce a noisy async bit into a registered level plus one-cycle change strobes.
// Latency : SYNC_STAGES+STABLE_CYCLES-1 edges from a stable raw_in change to dout/en_out update.
// Backpressure: none; en_out is a fire-and-forget enable for the downstream flop.
// Ports   : clock, reset (async active-low), raw_in (noisy), clear (sync clear),
//           dout (level), en_out/rise/fall (strobes), busy (FSM not IDLE).
module debounce_strobe
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  input  logic clear,
  output logic dout,
  output logic en_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_sync_q;
  logic             w_diff;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;
  logic             r_en;
  logic             r_rise;
  logic             r_fall;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dout_nxt;
  logic             w_en_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (raw_in),
    .q     (w_sync_q)
  );

  assign w_diff = (w_sync_q != r_dout);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_en    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_en    <= w_en_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Strobes default low: they are only raised on the single commit edge,
  // which guarantees they never stay high across consecutive cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_en_nxt    = 1'b0;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_diff) begin
          w_state_nxt = QUALIFY;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      QUALIFY: begin
        if (!w_diff) begin
          // Glitch shorter than the qualify window: drop it silently.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = COMMIT;
          w_dout_nxt  = w_sync_q;
          w_en_nxt    = 1'b1;
          w_rise_nxt  = w_sync_q;
          w_fall_nxt  = ~w_sync_q;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      COMMIT: begin
        // One dead cycle so the strobe can never be re-armed back to back.
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Clear wins over everything, including a commit on the same edge.
    if (clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_dout_nxt  = 1'b0;
      w_en_nxt    = 1'b0;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
    end
  end

  assign dout   = r_dout;
  assign en_out = r_en;
  assign rise   = r_rise;
  assign fall   = r_fall;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_debounce_strobe.sv
// Purpose : self-checking bench for debounce_strobe against a run-length reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_debounce_strobe;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic raw_in = 1'b0;
  logic clear = 1'b0;
  logic dout, en_out, rise, fall, busy;

  logic ff_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pulse-width view of the debouncer.
  logic m_sync [SYNC];
  int   m_run;
  logic m_blind;
  logic m_dout, m_en, m_rise, m_fall, m_ff;

  always #5 clock = ~clock;

  debounce_strobe #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .CNT_W         (3)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .raw_in (raw_in),
    .clear  (clear),
    .dout   (dout),
    .en_out (en_out),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  // Downstream enabled D flip-flop fed by the debouncer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ff_q <= 1'b0;
    else if (en_out) ff_q <= dout;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    m_run = 0; m_blind = 1'b0;
    m_dout = 1'b0; m_en = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_ff = 1'b0;
  endtask

  // One rising edge of the model, using the inputs the DUT also sees.
  task automatic m_edge();
    logic sq, old_en, old_dout;
    old_en = m_en; old_dout = m_dout;
    sq = m_sync[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = raw_in;
    m_en = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    if (old_en) m_ff = old_dout;
    if (clear) begin
      m_run = 0; m_blind = 1'b0; m_dout = 1'b0;
    end else if (m_blind) begin
      m_blind = 1'b0; m_run = 0;
    end else if (sq != m_dout) begin
      m_run++;
      if (m_run == STABLE) begin
        m_dout = sq; m_en = 1'b1; m_rise = sq; m_fall = ~sq;
        m_run = 0; m_blind = 1'b1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_all();
    chk("dout", dout, m_dout);
    chk("en_out", en_out, m_en);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("busy", busy, int'(m_run > 0 || m_blind));
    chk("flop", ff_q, m_ff);
  endtask

  // Advance one clock: model follows the edge, outputs checked mid-cycle.
  task automatic step();
    @(posedge clock);
    m_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge clock);
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    int first_edge, busy_cnt, en_cnt, len;
    m_reset();

    // Reset held with raw_in high: everything stays at zero.
    raw_in = 1'b1;
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b1;

    // Released before edge 0: commit must land on edge 5.
    first_edge = -1;
    for (int e = 0; e < 9; e++) begin
      step();
      if (dout && first_edge < 0) begin
        first_edge = e;
        chk("lat_en", en_out, 1);
        chk("lat_rise", rise, 1);
      end
    end
    chk("lat_edge", first_edge, SYNC + STABLE - 1);

    // 3-clock low glitch: rejected, busy for exactly 3 cycles.
    busy_cnt = 0; en_cnt = 0;
    raw_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) raw_in = 1'b1;
      step();
      busy_cnt += int'(busy);
      en_cnt   += int'(en_out);
    end
    chk("glitch_busy", busy_cnt, 3);
    chk("glitch_en", en_cnt, 0);
    chk("glitch_dout", dout, 1);

    // 4-clock low pulse: accepted as a fall, single strobe.
    en_cnt = 0;
    raw_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) raw_in = 1'b1;
      step();
      en_cnt += int'(fall);
    end
    chk("pulse4_fall", en_cnt, 1);

    // Let it settle high again, then toggle every clock for 20 clocks.
    repeat (10) step();
    raw_in = 1'b0;
    repeat (10) step();
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      raw_in = ~raw_in;
      step();
      en_cnt += int'(en_out);
    end
    chk("toggle_en", en_cnt, 0);
    raw_in = 1'b1;
    en_cnt = 0;
    repeat (12) begin
      step();
      en_cnt += int'(rise);
    end
    chk("toggle_rise", en_cnt, 1);

    // Clear on the very edge a fall would commit.
    raw_in = 1'b0;
    repeat (SYNC + STABLE - 1) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_en", en_out, 0);
    chk("clr_dout", dout, 0);
    chk("clr_busy", busy, 0);

    // Reset mid-qualify (cnt=2), then raw_in low steady: no strobe.
    repeat (4) step();
    raw_in = 1'b1;
    repeat (SYNC + 2) step();
    chk("pre_rst_busy", busy, 1);
    raw_in = 1'b0;
    async_reset();
    en_cnt = 0;
    repeat (10) begin
      step();
      en_cnt += int'(en_out);
    end
    chk("post_rst_en", en_cnt, 0);

    // Drive the downstream flop through 0->1->0, 8 clocks each.
    raw_in = 1'b1;
    repeat (8) step();
    raw_in = 1'b0;
    repeat (8) step();
    repeat (4) step();

    // Random run lengths, occasional clear and async reset.
    for (int i = 0; i < 120; i++) begin
      len = $urandom_range(1, 7);
      raw_in = ~raw_in;
      for (int j = 0; j < len; j++) begin
        clear = ($urandom_range(0, 39) == 0);
        step();
      end
      clear = 1'b0;
      if ($urandom_range(0, 59) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
